compute_clock_enable_ctrl: RTL and testbench
============================================

// Module: compute_clock_enable_ctrl
// PURPOSE
//  Control-domain source of compute_clock_en for the clock distribution block. It runs the
//  compute clock for an exact number of enabled cycles per start request, and gates it
//  off while any stall source (cache/memory, host debug) is asserted or the MMCM is
//  unlocked. It also reports progress and completion to the controller.
//  It runs on control_clock; its enable output feeds the synchronous-CE compute clock buffer.
// PARAMETERS
//  COUNT_WIDTH   32  width of run_cycles and cycles_run
//  STALL_SRCS    2   number of independent stall request inputs
//  RESUME_DELAY  2   idle cycles (en low) after stall release before enable reasserts; >=1
// PORTS
//  clock             in   1            control_clock; all logic on rising edge
//  reset             in   1            asynchronous, active-high; clears all state
//  locked            in   1            clock-generator lock status
//  start             in   1            one-cycle request to begin a run
//  run_cycles        in   COUNT_WIDTH  enabled compute cycles requested; sampled with start
//  stall_req         in   STALL_SRCS   level stall requests; any bit set gates the clock
//  abort             in   1            terminate the current run, no done pulse
//  compute_clock_en  out  1            registered enable to the compute clock buffer
//  busy              out  1            high in every state except IDLE
//  stalled           out  1            high in STALL and RESUME
//  done              out  1            one-cycle pulse after the final enabled cycle
//  cycles_run        out  COUNT_WIDTH  count of enabled cycles in the current or last run
// BEHAVIOUR
//  - Reset: state=IDLE; compute_clock_en=0; busy=0; stalled=0; done=0; cycles_run=0;
//    target=0; resume counter=0.
//  - All outputs are registered. compute_clock_en=1 exactly while state==RUN. There is no
//    combinational path from any input to compute_clock_en.
//  - cycles_run increments by 1 on each edge where compute_clock_en==1.
//    Width is COUNT_WIDTH. It never exceeds target.
//  - IDLE
//    - start && locked && run_cycles!=0: latch target=run_cycles, clear cycles_run,
//      go to RUN. Enable is high in the cycle after start.
//    - start && run_cycles==0: go to DONE. There is zero enabled cycles.
//    - start && !locked: ignored; remain in IDLE.
//  - RUN, with priority as listed:
//    1. abort: go to IDLE.
//    2. cycles_run==target-1 (final enabled cycle): go to DONE. A simultaneous stall is ignored.
//    3. |stall_req || !locked: go to STALL. Enable is low in the next cycle.
//    4. Otherwise stay in RUN.
//  - STALL
//    - abort: go to IDLE.
//    - !(|stall_req) && locked: load resume counter=RESUME_DELAY-1, go to RESUME.
//  - RESUME: enable stays low.
//    - abort: go to IDLE.
//    - |stall_req || !locked: go back to STALL.
//    - counter==0: go to RUN.
//    - Otherwise decrement the counter.
//  - DONE: done=1 for exactly this cycle, then go to IDLE. cycles_run holds its final
//    value until the next accepted start.
//  - start while busy: ignored. run_cycles is sampled only on an accepted start.
//  - Abort keeps cycles_run at the partial count; done is not pulsed.
//  - Reset asserted mid-run: enable drops asynchronously to 0 with all other state.
//  - Total enabled cycles per completed run == target exactly, regardless of stall count
//    or timing.
// TESTING
//  - T1: locked=1, start with run_cycles=5, no stalls -> en=1 for exactly 5 consecutive
//    cycles starting 1 cycle after start; done pulses on the 6th cycle; cycles_run=5.
//  - T2: run_cycles=10; stall_req[0] high for 3 cycles after 4 enabled cycles; RESUME_DELAY=2
//    -> en low for 3+2 cycles, stalled=1 during that time; total en cycles=10; done once.
//  - T3: run_cycles=3; stall_req[1] rises in the 3rd enabled cycle -> completion wins:
//    DONE next cycle; no STALL entered; cycles_run=3.
//  - T4: start with run_cycles=0 -> en never high; done pulses 1 cycle after start;
//    busy high 1 cycle.
//  - T5: locked drops during RUN at cycles_run=7 of 20, returns after 4 cycles -> en low
//    from the next cycle; resumes after RESUME_DELAY; final cycles_run=20. start while
//    !locked in IDLE -> ignored.
//  - T6: abort at cycles_run=6 of 50; separately, reset asserted mid-RUN -> abort: IDLE,
//    en=0, no done, cycles_run=6. Reset: en=0 immediately (async), all outputs at reset values.

Source files
------------

// File: rtl/compute_clock_enable_ctrl_if.sv
// Control bundle between the run controller and the compute clock enable block.
// Carries the request/stall inputs and registered status/enable outputs; no backpressure.
interface compute_clock_enable_ctrl_if #(
  parameter int COUNT_WIDTH = 32,
  parameter int STALL_SRCS  = 2
);
  logic                   locked;
  logic                   start;
  logic [COUNT_WIDTH-1:0] run_cycles;
  logic [STALL_SRCS-1:0]  stall_req;
  logic                   abort;
  logic                   compute_clock_en;
  logic                   busy;
  logic                   stalled;
  logic                   done;
  logic [COUNT_WIDTH-1:0] cycles_run;

  modport master (
    output locked, start, run_cycles, stall_req, abort,
    input  compute_clock_en, busy, stalled, done, cycles_run
  );

  modport slave (
    input  locked, start, run_cycles, stall_req, abort,
    output compute_clock_en, busy, stalled, done, cycles_run
  );
endinterface

// File: rtl/compute_clock_enable_ctrl.sv
// Runs the compute clock for exactly run_cycles enabled cycles, gating it while stalled or unlocked.
// Enable is registered and rises 1 cycle after start; start while busy is dropped, no backpressure.
module compute_clock_enable_ctrl #(
  parameter int COUNT_WIDTH  = 32,
  parameter int STALL_SRCS   = 2,
  parameter int RESUME_DELAY = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  compute_clock_enable_ctrl_if.slave  ctrl
);

  localparam int RCW = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;
  localparam logic [RCW-1:0] RESUME_LOAD = RCW'(RESUME_DELAY - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUN    = 3'd1;
  localparam logic [2:0] STALL  = 3'd2;
  localparam logic [2:0] RESUME = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [COUNT_WIDTH-1:0] target;
  logic [COUNT_WIDTH-1:0] target_nxt;
  logic [COUNT_WIDTH-1:0] cycles_run_q;
  logic [RCW-1:0]         resume_cnt;
  logic [RCW-1:0]         resume_nxt;
  logic                   clear_cnt;
  logic                   en_q;
  logic                   busy_q;
  logic                   stalled_q;
  logic                   done_q;
  logic                   gate_req;
  logic                   last_cycle;

  assign gate_req   = (|ctrl.stall_req) || !ctrl.locked;
  assign last_cycle = (cycles_run_q == (target - COUNT_WIDTH'(1)));

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    resume_nxt = resume_cnt;
    clear_cnt  = 1'b0;
    case (state)
      IDLE: begin
        if (ctrl.start && ctrl.locked) begin
          target_nxt = ctrl.run_cycles;
          clear_cnt  = 1'b1;
          state_nxt  = (ctrl.run_cycles == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        // completion outranks a stall arriving on the final enabled cycle
        if (ctrl.abort) begin
          state_nxt = IDLE;
        end else if (last_cycle) begin
          state_nxt = DONE;
        end else if (gate_req) begin
          state_nxt = STALL;
        end
      end
      STALL: begin
        if (ctrl.abort) begin
          state_nxt = IDLE;
        end else if (!gate_req) begin
          resume_nxt = RESUME_LOAD;
          state_nxt  = RESUME;
        end
      end
      RESUME: begin
        if (ctrl.abort) begin
          state_nxt = IDLE;
        end else if (gate_req) begin
          state_nxt = STALL;
        end else if (resume_cnt == '0) begin
          state_nxt = RUN;
        end else begin
          resume_nxt = resume_cnt - RCW'(1);
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // outputs are decoded from the next state so they line up with the state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      target       <= '0;
      resume_cnt   <= '0;
      cycles_run_q <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      stalled_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state      <= state_nxt;
      target     <= target_nxt;
      resume_cnt <= resume_nxt;
      en_q       <= (state_nxt == RUN);
      busy_q     <= (state_nxt != IDLE);
      stalled_q  <= (state_nxt == STALL) || (state_nxt == RESUME);
      done_q     <= (state_nxt == DONE);
      if (clear_cnt) begin
        cycles_run_q <= '0;
      end else if (en_q) begin
        cycles_run_q <= cycles_run_q + COUNT_WIDTH'(1);
      end
    end
  end

  assign ctrl.compute_clock_en = en_q;
  assign ctrl.busy             = busy_q;
  assign ctrl.stalled          = stalled_q;
  assign ctrl.done             = done_q;
  assign ctrl.cycles_run       = cycles_run_q;

endmodule

// File: tb/tb_compute_clock_enable_ctrl.sv
// Directed and randomized checks of compute_clock_enable_ctrl against a window-based run model.
module tb_compute_clock_enable_ctrl;

  localparam int CW = 32;
  localparam int SS = 2;
  localparam int RD = 2;

  logic clock;
  logic reset;

  compute_clock_enable_ctrl_if #(.COUNT_WIDTH(CW), .STALL_SRCS(SS)) bus ();

  compute_clock_enable_ctrl #(
    .COUNT_WIDTH  (CW),
    .STALL_SRCS   (SS),
    .RESUME_DELAY (RD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .ctrl  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_assert;
  int n_fail;

  // expected run view: remaining enabled cycles, enabled cycles so far, and
  // how many consecutive cycles the gate condition has been clear
  logic        m_busy;
  logic        m_en;
  logic        m_done;
  logic        m_stalled;
  int unsigned m_rem;
  int unsigned m_cnt;
  int          m_quiet;
  int          n_done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_en = 0; m_done = 0; m_stalled = 0;
    m_rem = 0; m_cnt = 0; m_quiet = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".en"},         {31'd0, bus.compute_clock_en}, {31'd0, m_en});
    chk({tag, ".busy"},       {31'd0, bus.busy},             {31'd0, m_busy});
    chk({tag, ".stalled"},    {31'd0, bus.stalled},          {31'd0, m_stalled});
    chk({tag, ".done"},       {31'd0, bus.done},             {31'd0, m_done});
    chk({tag, ".cycles_run"}, bus.cycles_run,                m_cnt);
  endtask

  task automatic model_step(input logic st, input logic [31:0] rc, input logic [1:0] sr,
                            input logic lk, input logic ab);
    logic bad;
    logic was_en;
    bad     = (|sr) || !lk;
    m_quiet = bad ? 0 : m_quiet + 1;
    if (!m_busy) begin
      if (st && lk) begin
        m_cnt     = 0;
        m_rem     = rc;
        m_busy    = 1;
        m_done    = (rc == 0);
        m_en      = (rc != 0);
        m_stalled = 0;
      end
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else begin
      was_en = m_en;
      if (was_en) begin
        m_cnt++;
        m_rem--;
      end
      if (ab) begin
        m_busy = 0; m_en = 0; m_stalled = 0;
      end else if (was_en && m_rem == 0) begin
        m_en = 0; m_done = 1; m_stalled = 0;
      end else begin
        // gated runs restart only after RD+1 consecutive clear samples
        m_en      = was_en ? !bad : (m_quiet >= RD + 1);
        m_stalled = !m_en;
      end
    end
  endtask

  task automatic step(input string tag, input logic st, input logic [31:0] rc,
                      input logic [1:0] sr, input logic lk, input logic ab);
    bus.start      = st;
    bus.run_cycles = rc;
    bus.stall_req  = sr;
    bus.locked     = lk;
    bus.abort      = ab;
    model_step(st, rc, sr, lk, ab);
    @(posedge clock);
    @(negedge clock);
    if (bus.done === 1'b1) n_done_seen++;
    check_all(tag);
  endtask

  task automatic idle_steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 32'd0, 2'b00, 1'b1, 1'b0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    n_done_seen = 0;
    model_reset();
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.run_cycles = '0;
    bus.stall_req  = '0;
    bus.locked     = 1'b1;
    bus.abort      = 1'b0;
    @(negedge clock);
    check_all("reset");
    reset = 1'b0;

    // T1: plain run of 5
    n_done_seen = 0;
    step("t1.start", 1'b1, 32'd5, 2'b00, 1'b1, 1'b0);
    idle_steps("t1", 8);
    chk("t1.final_cycles", bus.cycles_run, 32'd5);
    chk("t1.done_count", n_done_seen, 32'd1);

    // T2: run of 10 with a 3-cycle stall on source 0
    n_done_seen = 0;
    step("t2.start", 1'b1, 32'd10, 2'b00, 1'b1, 1'b0);
    idle_steps("t2.pre", 3);
    for (int i = 0; i < 3; i++) step("t2.stall", 1'b0, 32'd0, 2'b01, 1'b1, 1'b0);
    idle_steps("t2.post", 14);
    chk("t2.final_cycles", bus.cycles_run, 32'd10);
    chk("t2.done_count", n_done_seen, 32'd1);

    // T3: stall on final enabled cycle loses to completion
    step("t3.start", 1'b1, 32'd3, 2'b00, 1'b1, 1'b0);
    idle_steps("t3.pre", 2);
    step("t3.laststall", 1'b0, 32'd0, 2'b10, 1'b1, 1'b0);
    chk("t3.done_now", {31'd0, bus.done}, 32'd1);
    idle_steps("t3.post", 3);
    chk("t3.final_cycles", bus.cycles_run, 32'd3);

    // T4: zero-length run
    step("t4.start", 1'b1, 32'd0, 2'b00, 1'b1, 1'b0);
    idle_steps("t4", 3);

    // T5: start while unlocked is ignored, then lock loss mid-run
    step("t5.nolock", 1'b1, 32'd9, 2'b00, 1'b0, 1'b0);
    chk("t5.ignored", {31'd0, bus.busy}, 32'd0);
    step("t5.start", 1'b1, 32'd20, 2'b00, 1'b1, 1'b0);
    idle_steps("t5.pre", 7);
    for (int i = 0; i < 4; i++) step("t5.unlock", 1'b0, 32'd0, 2'b00, 1'b0, 1'b0);
    idle_steps("t5.post", 20);
    chk("t5.final_cycles", bus.cycles_run, 32'd20);

    // T6: abort keeps partial count; start while busy is ignored
    n_done_seen = 0;
    step("t6.start", 1'b1, 32'd50, 2'b00, 1'b1, 1'b0);
    step("t6.busy_start", 1'b1, 32'd3, 2'b00, 1'b1, 1'b0);
    idle_steps("t6.pre", 4);
    step("t6.abort", 1'b0, 32'd0, 2'b00, 1'b1, 1'b1);
    idle_steps("t6.post", 3);
    chk("t6.partial", bus.cycles_run, 32'd6);
    chk("t6.no_done", n_done_seen, 32'd0);

    // asynchronous reset in the middle of a run
    step("t6r.start", 1'b1, 32'd50, 2'b00, 1'b1, 1'b0);
    idle_steps("t6r.pre", 4);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("t6r.async");
    @(negedge clock);
    check_all("t6r.held");
    reset = 1'b0;

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic       st;
      logic       lk;
      logic       ab;
      logic [1:0] sr;
      logic [31:0] rc;
      st = ($urandom_range(0, 7) == 0);
      rc = $urandom_range(0, 12);
      sr = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      lk = ($urandom_range(0, 15) != 0);
      ab = ($urandom_range(0, 40) == 0);
      step("rand", st, rc, sr, lk, ab);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
